// File: rtl/fifo_one_depth_rr_arbiter.sv
// Round-robin write arbiter feeding a single-entry slot drained by one consumer.
// Ports: clk, reset (async, active-high); req_i/wdata_i/gnt_o on the write side;
// rden_i/rdata_o/rsrc_o/full_o/empty_o on the read side.
// Optional macro FIFO_ARB_REFILL_EN: allow grant+reload in the same cycle as a pop.
module fifo_one_depth_rr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SRC_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    input  logic                          rden_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [SRC_W-1:0]              rsrc_o,
    output logic                          full_o,
    output logic                          empty_o
);

`ifdef FIFO_ARB_REFILL_EN
    localparam bit REFILL = 1'b1;
`else
    localparam bit REFILL = 1'b0;
`endif

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [SRC_W-1:0] ptr_q;
    logic [SRC_W-1:0] winner;
    logic             found;
    logic             can_grant;
    logic             do_grant;

    // ptr + offset folded back into 0..NUM_REQ-1 (offset < NUM_REQ).
    function automatic logic [SRC_W-1:0] wrap_idx(input int v);
        return (v >= NUM_REQ) ? SRC_W'(v - NUM_REQ) : SRC_W'(v);
    endfunction

    // First asserted request at or after the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_i[wrap_idx(int'(ptr_q) + i)]) begin
                found  = 1'b1;
                winner = wrap_idx(int'(ptr_q) + i);
            end
        end
    end

    // The slot accepts a write when empty, or (refill only) when it is
    // being popped in the same cycle.
    assign can_grant = (state_q == S_EMPTY) ||
                       (REFILL && (state_q == S_FULL) && rden_i);
    assign do_grant  = can_grant && found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: begin
                if (do_grant) state_d = S_FULL;
            end
            S_FULL: begin
                if (rden_i && !do_grant) state_d = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        gnt_o = '0;
        if (do_grant) gnt_o[winner] = 1'b1;
        full_o  = (state_q == S_FULL);
        empty_o = (state_q != S_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_o <= '0;
            rsrc_o  <= '0;
            ptr_q   <= '0;
        end else if (do_grant) begin
            rdata_o <= wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
            rsrc_o  <= winner;
            ptr_q   <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + SRC_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_one_depth_rr_arbiter.sv
// Directed self-checking bench for fifo_one_depth_rr_arbiter.
// Builds with or without FIFO_ARB_REFILL_EN; expectations follow the macro.
module tb_fifo_one_depth_rr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_i;
    logic [255:0] wdata_i;
    logic [3:0]   gnt_o;
    logic         rden_i;
    logic [63:0]  rdata_o;
    logic [1:0]   rsrc_o;
    logic         full_o;
    logic         empty_o;

    int n_checks = 0;
    int n_errors = 0;

    fifo_one_depth_rr_arbiter #(
        .NUM_REQ(4),
        .DATA_WIDTH(64),
        .SRC_W(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_i(req_i),
        .wdata_i(wdata_i),
        .gnt_o(gnt_o),
        .rden_i(rden_i),
        .rdata_o(rdata_o),
        .rsrc_o(rsrc_o),
        .full_o(full_o),
        .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int k, input logic [63:0] v);
        wdata_i[k*64 +: 64] = v;
    endtask

    logic [3:0] exp_g;

    initial begin
        reset   = 1'b1;
        req_i   = '0;
        rden_i  = 1'b0;
        wdata_i = '0;
        for (int k = 0; k < 4; k++) set_lane(k, 64'h100 + 64'(k));
        #1;
        check("rst_full", {63'd0, full_o}, 64'd0);
        check("rst_empty", {63'd0, empty_o}, 64'd1);
        check("rst_rdata", rdata_o, 64'd0);
        check("rst_rsrc", {62'd0, rsrc_o}, 64'd0);
        check("rst_gnt", {60'd0, gnt_o}, 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;

        // Single request from lane 2; pointer moves to 3.
        set_lane(2, 64'hA5);
        req_i = 4'b0100;
        #1;
        check("single_gnt", {60'd0, gnt_o}, 64'h4);
        step();
        req_i = 4'b0000;
        #1;
        check("single_full", {63'd0, full_o}, 64'd1);
        check("single_rdata", rdata_o, 64'hA5);
        check("single_rsrc", {62'd0, rsrc_o}, 64'd2);
        check("single_gnt0", {60'd0, gnt_o}, 64'd0);
        rden_i = 1'b1;
        step();
        rden_i = 1'b0;
        #1;
        check("single_pop", {63'd0, empty_o}, 64'd1);

        // Wrap: pointer at 3 with requesters 3 and 0.
        req_i = 4'b1001;
        #1;
        check("wrap_gnt3", {60'd0, gnt_o}, 64'h8);
        step();
        req_i = 4'b0001;
        #1;
        check("wrap_rsrc3", {62'd0, rsrc_o}, 64'd3);
        check("wrap_hold", {60'd0, gnt_o}, 64'd0);
        rden_i = 1'b1;
        #1;
`ifdef FIFO_ARB_REFILL_EN
        check("wrap_refill", {60'd0, gnt_o}, 64'h1);
        step();
`else
        check("wrap_norefill", {60'd0, gnt_o}, 64'd0);
        step();
        check("wrap_gnt0", {60'd0, gnt_o}, 64'h1);
        rden_i = 1'b0;
        step();
`endif
        req_i  = 4'b0000;
        rden_i = 1'b0;
        #1;
        check("wrap_rsrc0", {62'd0, rsrc_o}, 64'd0);
        check("wrap_full0", {63'd0, full_o}, 64'd1);
        rden_i = 1'b1;
        step();
        rden_i = 1'b0;
        #1;
        check("wrap_pop", {63'd0, empty_o}, 64'd1);

        // Back-pressure: pointer at 1, requesters 0 and 1.
        set_lane(1, 64'h1111);
        req_i = 4'b0011;
        #1;
        check("bp_gnt1", {60'd0, gnt_o}, 64'h2);
        step();
        set_lane(1, 64'h2222);
        check("bp_rsrc", {62'd0, rsrc_o}, 64'd1);
        for (int c = 0; c < 10; c++) begin
            check("bp_gnt", {60'd0, gnt_o}, 64'd0);
            check("bp_rdata", rdata_o, 64'h1111);
            step();
        end

        // Asynchronous reset in mid-cycle with the slot full.
        #2;
        reset = 1'b1;
        #1;
        check("arst_full", {63'd0, full_o}, 64'd0);
        check("arst_empty", {63'd0, empty_o}, 64'd1);
        check("arst_rdata", rdata_o, 64'd0);
        step();
        reset = 1'b0;
        #1;
        check("arst_gnt0", {60'd0, gnt_o}, 64'h1);
        step();
        req_i = 4'b0000;
        #1;
        check("arst_rdata0", rdata_o, 64'h100);
        rden_i = 1'b1;
        step();

        // Pop while empty: no effect, pointer stays at 1.
        for (int c = 0; c < 3; c++) begin
            check("pe_empty", {63'd0, empty_o}, 64'd1);
            check("pe_gnt", {60'd0, gnt_o}, 64'd0);
            step();
        end
        req_i = 4'b0011;
        #1;
        check("pe_ptr", {60'd0, gnt_o}, 64'h2);
        req_i = 4'b0001;
        #1;
        check("pe_gnt0", {60'd0, gnt_o}, 64'h1);
        step();
        req_i = 4'b0000;
        #1;
        check("pe_rsrc", {62'd0, rsrc_o}, 64'd0);
        step();
        rden_i = 1'b0;
        #1;
        check("pe_drain", {63'd0, empty_o}, 64'd1);

        // Round-robin under continuous demand, starting from pointer 0.
        reset = 1'b1;
        step();
        reset  = 1'b0;
        req_i  = 4'b1111;
        rden_i = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
`ifdef FIFO_ARB_REFILL_EN
            exp_g = 4'b0001 << (c % 4);
`else
            exp_g = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
`endif
            check("rr_gnt", {60'd0, gnt_o}, {60'd0, exp_g});
            step();
        end
        req_i  = 4'b0000;
        rden_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
